// File: rtl/hazard_seq_if.sv
// rtl/hazard_seq_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_seq_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        MemBusy, MemTimeout;
  logic [15:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemBusy, MemTimeout, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemBusy, MemTimeout, StallCount
  );
endinterface

// File: rtl/hazard_seq.sv
// rtl/hazard_seq.sv - pipeline hazard unit with forwarding, load-use stall and memory-wait FSM
module hazard_seq (
  input  logic         clk,
  input  logic         reset,
  hazard_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        busy_q, timeout_q;

  logic        lw_stall, mem_stall, stall_f;
  logic [1:0]  fwd_a, fwd_b;

  assign fwd_a = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs1E) ? 2'b10 :
                 (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs1E) ? 2'b01 : 2'b00;
  assign fwd_b = (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == bus.Rs2E) ? 2'b10 :
                 (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs2E) ? 2'b01 : 2'b00;

  assign lw_stall  = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                     (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
  // A ready access in IDLE completes in place, so it never stalls.
  assign mem_stall = (state_q == IDLE && bus.MemReqM && !bus.MemReadyM) ||
                     (state_q == WAIT) || (state_q == ERR);
  assign stall_f   = reset && (mem_stall || lw_stall);

  assign bus.ForwardAE  = reset ? fwd_a : 2'b00;
  assign bus.ForwardBE  = reset ? fwd_b : 2'b00;
  assign bus.StallF     = stall_f;
  assign bus.StallD     = stall_f;
  assign bus.StallE     = reset && mem_stall;
  assign bus.StallM     = reset && mem_stall;
  assign bus.FlushW     = reset && mem_stall;
  // A branch held in Execute by a memory stall flushes once the stall lifts.
  assign bus.FlushD     = reset && bus.PCSrcE && !mem_stall;
  assign bus.FlushE     = reset && (lw_stall || bus.PCSrcE) && !mem_stall;
  assign bus.MemBusy    = reset && busy_q;
  assign bus.MemTimeout = timeout_q;
  assign bus.StallCount = stall_cnt_q;

  assign stall_cnt_d = (stall_f && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        IDLE: begin
          if (bus.MemReqM && !bus.MemReadyM) begin
            state_q    <= WAIT;
            wait_cnt_q <= 8'd0;
            busy_q     <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.MemReadyM) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wait_cnt_q == 8'd255) begin
            state_q   <= ERR;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ERR: begin
          busy_q    <= 1'b1;
          timeout_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_seq.sv
// tb/tb_hazard_seq.sv - directed self-checking bench for hazard_seq
module tb_hazard_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_seq_if bus ();

  hazard_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    bus.RdE  = 5'd0; bus.RdM  = 5'd0; bus.RdW  = 5'd0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.ResultSrcE0 = 1'b0;
    bus.PCSrcE = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b0;
    // Inputs that would otherwise raise every output while reset is held.
    bus.MemReqM = 1'b1; bus.PCSrcE = 1'b1; bus.RegWriteM = 1'b1;
    bus.RdM = 5'd3; bus.Rs1E = 5'd3; bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
    tick(); tick(); #1;
    chk("rst_stallf", bus.StallF, 0);
    chk("rst_stalle", bus.StallE, 0);
    chk("rst_flushd", bus.FlushD, 0);
    chk("rst_flushe", bus.FlushE, 0);
    chk("rst_flushw", bus.FlushW, 0);
    chk("rst_busy", bus.MemBusy, 0);
    chk("rst_fwda", bus.ForwardAE, 0);
    chk("rst_timeout", bus.MemTimeout, 0);
    chk("rst_count", bus.StallCount, 0);

    reset = 1'b1; clear_inputs(); tick();

    // Forwarding
    bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1; bus.Rs1E = 5'd5; #1;
    chk("fwd_a_mem", bus.ForwardAE, 2'b10);
    chk("fwd_b_none", bus.ForwardBE, 2'b00);
    bus.RdM = 5'd0; #1;
    chk("fwd_a_wb", bus.ForwardAE, 2'b01);
    bus.Rs2E = 5'd9; bus.RdM = 5'd9; bus.RegWriteW = 1'b0; #1;
    chk("fwd_b_mem", bus.ForwardBE, 2'b10);
    chk("fwd_a_off", bus.ForwardAE, 2'b00);
    bus.RegWriteM = 1'b0; #1;
    chk("fwd_b_nowe", bus.ForwardBE, 2'b00);
    clear_inputs();

    // Load-use stall
    bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7; #1;
    chk("lw_stallf", bus.StallF, 1);
    chk("lw_stalld", bus.StallD, 1);
    chk("lw_flushe", bus.FlushE, 1);
    chk("lw_stalle", bus.StallE, 0);
    chk("lw_flushd", bus.FlushD, 0);
    tick();
    bus.RdE = 5'd0; bus.Rs2D = 5'd0; #1;
    chk("lw_rd0_stallf", bus.StallF, 0);
    chk("lw_rd0_flushe", bus.FlushE, 0);
    chk("lw_count", bus.StallCount, 1);
    clear_inputs();

    reset = 1'b0; tick(); reset = 1'b1;

    // Memory wait: two not-ready cycles, ready on the third
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; #1;
    chk("mw0_stallf", bus.StallF, 1);
    chk("mw0_stallm", bus.StallM, 1);
    chk("mw0_flushw", bus.FlushW, 1);
    chk("mw0_busy", bus.MemBusy, 0);
    tick(); #1;
    chk("mw1_stalle", bus.StallE, 1);
    chk("mw1_busy", bus.MemBusy, 1);
    tick();
    bus.MemReadyM = 1'b1; #1;
    chk("mw2_stalld", bus.StallD, 1);
    chk("mw2_busy", bus.MemBusy, 1);
    tick();
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0; #1;
    chk("mw3_stallf", bus.StallF, 0);
    chk("mw3_busy", bus.MemBusy, 0);
    chk("mw3_count", bus.StallCount, 3);

    // Ready access in IDLE inserts no stall
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1; #1;
    chk("rdy_stallf", bus.StallF, 0);
    tick(); #1;
    chk("rdy_busy", bus.MemBusy, 0);
    chk("rdy_count", bus.StallCount, 3);

    // Branch and load hazard frozen behind a memory stall
    bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1; #1;
    chk("br0_flushd", bus.FlushD, 0);
    chk("br0_flushe", bus.FlushE, 0);
    tick();
    bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd2; bus.Rs1D = 5'd2; #1;
    chk("br1_flushe", bus.FlushE, 0);
    chk("br1_stalle", bus.StallE, 1);
    bus.ResultSrcE0 = 1'b0; bus.MemReadyM = 1'b1; #1;
    chk("br1_flushd", bus.FlushD, 0);
    tick();
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0; #1;
    chk("br2_flushd", bus.FlushD, 1);
    chk("br2_flushe", bus.FlushE, 1);
    chk("br2_stallf", bus.StallF, 0);
    tick();
    bus.PCSrcE = 1'b0; #1;
    chk("br3_flushd", bus.FlushD, 0);
    clear_inputs();

    // Reset in the middle of WAIT
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rw_hold_stallf", bus.StallF, 0);
    chk("rw_hold_busy", bus.MemBusy, 0);
    tick();
    reset = 1'b1; bus.MemReqM = 1'b0; #1;
    chk("rw_busy", bus.MemBusy, 0);
    chk("rw_stallm", bus.StallM, 0);
    chk("rw_timeout", bus.MemTimeout, 0);
    chk("rw_count", bus.StallCount, 0);
    tick();

    // Timeout after 256 WAIT cycles
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    tick();
    repeat (255) tick();
    #1;
    chk("to_pre_timeout", bus.MemTimeout, 0);
    chk("to_pre_busy", bus.MemBusy, 1);
    tick(); #1;
    chk("to_timeout", bus.MemTimeout, 1);
    chk("to_count", bus.StallCount, 257);
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b1;
    tick(); #1;
    chk("err_sticky", bus.MemTimeout, 1);
    chk("err_stallf", bus.StallF, 1);
    chk("err_busy", bus.MemBusy, 1);

    // Stall counter saturates
    repeat (65400) tick();
    #1;
    chk("count_sat", bus.StallCount, 16'hFFFF);

    // Reset out of ERR
    reset = 1'b0; tick();
    reset = 1'b1; clear_inputs(); #1;
    chk("err_rst_timeout", bus.MemTimeout, 0);
    chk("err_rst_stallf", bus.StallF, 0);
    chk("err_rst_busy", bus.MemBusy, 0);
    chk("err_rst_count", bus.StallCount, 0);
    tick(); #1;
    chk("err_rst_flushw", bus.FlushW, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
